// File: rtl/dma_ci_pkg.sv
// Shared definitions for the CI burst DMA engine.
// Register selects, control/status bit positions and FSM states.
package dma_ci_pkg;

  localparam logic [2:0] SEL_MEM      = 3'd0;
  localparam logic [2:0] SEL_BUS_ADDR = 3'd1;
  localparam logic [2:0] SEL_MEM_ADDR = 3'd2;
  localparam logic [2:0] SEL_BLOCK    = 3'd3;
  localparam logic [2:0] SEL_BURST    = 3'd4;
  localparam logic [2:0] SEL_CTRL     = 3'd5;

  localparam int CTRL_RD   = 0;
  localparam int CTRL_WR   = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_INIT,
    ST_READ,
    ST_WRITE,
    ST_END,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/dma_dp_ram.sv
// True dual-port 32-bit scratch SSRAM, registered reads on both ports.
// Port A serves the CI, port B serves the DMA engine.
module dma_dp_ram #(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Port B is written last so a DMA write wins an address collision
  always_ff @(posedge clock) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Port A read register
  always_ff @(posedge clock) begin
    a_rdata <= mem[a_addr];
  end

  // Port B read register
  always_ff @(posedge clock) begin
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/dma_ci_burst_engine.sv
// CI-mapped scratch SSRAM and register file with a burst DMA master.
// Blocks move bus->SSRAM or SSRAM->bus, split into bursts.
module dma_ci_burst_engine
  import dma_ci_pkg::*;
#(
  parameter logic [7:0] customId   = 8'h00,
  parameter int         MEM_ADDR_W = 9,
  parameter int         BLOCK_W    = 10,
  parameter int         BURST_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  output logic        beginTransactionOut,
  output logic [31:0] addressDataOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn
);

  localparam int M = MEM_ADDR_W;

  state_t state, state_nxt;

  logic [31:0]        bus_addr;
  logic [M-1:0]       mem_addr;
  logic [BLOCK_W-1:0] block_size;
  logic [BURST_W-1:0] burst_size;
  logic               err;

  logic [31:0]        wk_bus;
  logic [M-1:0]       wk_ptr;
  logic [BLOCK_W-1:0] wk_rem;
  logic [BLOCK_W-1:0] beat_cnt;
  logic               wk_read;

  logic               ci_hit, ci_wr, busy;
  logic               cfg_wr, go;
  logic [2:0]         ci_sel;
  logic [31:0]        reg_rd;
  logic               done_r, use_ram;
  logic [31:0]        rd_val;

  logic [31:0]        burst_len, rem_ext, beats;
  logic [BLOCK_W-1:0] rem_after;

  logic               a_we, b_we;
  logic [31:0]        a_rdata, b_rdata;
  logic               unused;

  assign unused = ^valueA[31:M+4];

  assign ci_hit = start && (ciN == customId);
  assign ci_wr  = ci_hit && valueA[M];
  assign ci_sel = valueA[M+3:M+1];
  assign busy   = (state != ST_IDLE);
  assign cfg_wr = ci_wr && !busy;
  assign go     = cfg_wr && (ci_sel == SEL_CTRL)
                && (valueB[CTRL_RD] || valueB[CTRL_WR])
                && (|block_size);

  assign burst_len = 32'(burst_size) + 32'd1;
  assign rem_ext   = 32'(wk_rem);
  assign beats     = (burst_len < rem_ext) ? burst_len : rem_ext;
  assign rem_after = wk_rem - BLOCK_W'(dataValidIn);

  assign a_we = ci_wr && (ci_sel == SEL_MEM);
  assign b_we = (state == ST_READ) && dataValidIn;

  dma_dp_ram #(
    .ADDR_W (M)
  ) u_ram (
    .clock   (clock),
    .a_we    (a_we),
    .a_addr  (valueA[M-1:0]),
    .a_wdata (valueB),
    .a_rdata (a_rdata),
    .b_we    (b_we),
    .b_addr  (wk_ptr),
    .b_wdata (addressDataIn),
    .b_rdata (b_rdata)
  );

  // Register readback mux; control select reads back status
  always_comb begin
    reg_rd = '0;
    case (ci_sel)
      SEL_BUS_ADDR: reg_rd = bus_addr;
      SEL_MEM_ADDR: reg_rd = 32'(mem_addr);
      SEL_BLOCK:    reg_rd = 32'(block_size);
      SEL_BURST:    reg_rd = 32'(burst_size);
      SEL_CTRL: begin
        reg_rd[STAT_BUSY] = busy;
        reg_rd[STAT_ERR]  = err;
      end
      default:      reg_rd = '0;
    endcase
  end

  // CI response: done one cycle after start, result only while done
  always_ff @(posedge clock) begin
    if (reset) begin
      done_r  <= 1'b0;
      use_ram <= 1'b0;
      rd_val  <= '0;
    end else begin
      done_r  <= ci_hit;
      use_ram <= ci_hit && !ci_wr && (ci_sel == SEL_MEM);
      rd_val  <= (ci_hit && !ci_wr) ? reg_rd : '0;
    end
  end

  assign done   = done_r;
  assign result = !done_r ? '0 : (use_ram ? a_rdata : rd_val);

  // Config registers; writes are dropped while a transfer runs
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_addr   <= '0;
      mem_addr   <= '0;
      block_size <= '0;
      burst_size <= '0;
    end else if (cfg_wr) begin
      case (ci_sel)
        SEL_BUS_ADDR: bus_addr   <= valueB;
        SEL_MEM_ADDR: mem_addr   <= valueB[M-1:0];
        SEL_BLOCK:    block_size <= valueB[BLOCK_W-1:0];
        SEL_BURST:    burst_size <= valueB[BURST_W-1:0];
        default: ;
      endcase
    end
  end

  // Sticky error flag, cleared by any accepted control write
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == ST_ERROR) begin
      err <= 1'b1;
    end else if (cfg_wr && (ci_sel == SEL_CTRL)) begin
      err <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and wired-OR bus outputs, zero outside a burst
  always_comb begin
    state_nxt           = state;
    requestTransaction  = 1'b0;
    beginTransactionOut = 1'b0;
    addressDataOut      = '0;
    burstSizeOut        = '0;
    readNotWriteOut     = 1'b0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_REQUEST;
      end
      ST_REQUEST: begin
        requestTransaction = 1'b1;
        if (transactionGranted) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = wk_bus;
        burstSizeOut        = 8'(beats - 32'd1);
        readNotWriteOut     = wk_read;
        state_nxt = wk_read ? ST_READ : ST_WRITE;
      end
      ST_READ: begin
        if (endTransactionIn)
          state_nxt = (|rem_after) ? ST_REQUEST : ST_IDLE;
      end
      ST_WRITE: begin
        dataValidOut   = 1'b1;
        addressDataOut = b_rdata;
        if (beat_cnt == BLOCK_W'(1)) state_nxt = ST_END;
      end
      ST_END: begin
        endTransactionOut = 1'b1;
        state_nxt = (|wk_rem) ? ST_REQUEST : ST_IDLE;
      end
      ST_ERROR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (busErrorIn && (state != ST_IDLE) && (state != ST_ERROR))
      state_nxt = ST_ERROR;
  end

  // Working copies: loaded on start, advanced per burst and per beat
  always_ff @(posedge clock) begin
    if (reset) begin
      wk_bus   <= '0;
      wk_ptr   <= '0;
      wk_rem   <= '0;
      beat_cnt <= '0;
      wk_read  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            wk_bus  <= bus_addr;
            wk_ptr  <= mem_addr;
            wk_rem  <= block_size;
            wk_read <= valueB[CTRL_RD];
          end
        end
        ST_INIT: begin
          wk_bus   <= wk_bus + {beats[29:0], 2'b00};
          beat_cnt <= BLOCK_W'(beats);
          if (!wk_read) wk_ptr <= wk_ptr + 1'b1;
        end
        ST_READ: begin
          if (dataValidIn) begin
            wk_ptr <= wk_ptr + 1'b1;
            wk_rem <= wk_rem - 1'b1;
          end
        end
        ST_WRITE: begin
          wk_rem   <= wk_rem - 1'b1;
          beat_cnt <= beat_cnt - 1'b1;
          if (beat_cnt != BLOCK_W'(1)) wk_ptr <= wk_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ci_burst_engine.sv
// Scoreboard bench for dma_ci_burst_engine: CI ops and bus bursts
// are predicted from a transfer-level model and popped by a monitor.
module tb_dma_ci_burst_engine;

  localparam int M     = 9;
  localparam int DEPTH = 1 << M;

  localparam logic [2:0] S_MEM = 3'd0;
  localparam logic [2:0] S_BUS = 3'd1;
  localparam logic [2:0] S_MA  = 3'd2;
  localparam logic [2:0] S_BLK = 3'd3;
  localparam logic [2:0] S_BST = 3'd4;
  localparam logic [2:0] S_CTL = 3'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA, valueB;
  logic        done;
  logic [31:0] result;
  logic        requestTransaction, transactionGranted;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut, dataValidOut, endTransactionOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn, endTransactionIn, busErrorIn;

  always #5 clock = ~clock;

  dma_ci_burst_engine dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .ciN                 (ciN),
    .valueA              (valueA),
    .valueB              (valueB),
    .done                (done),
    .result              (result),
    .requestTransaction  (requestTransaction),
    .transactionGranted  (transactionGranted),
    .beginTransactionOut (beginTransactionOut),
    .addressDataOut      (addressDataOut),
    .burstSizeOut        (burstSizeOut),
    .readNotWriteOut     (readNotWriteOut),
    .dataValidOut        (dataValidOut),
    .endTransactionOut   (endTransactionOut),
    .addressDataIn       (addressDataIn),
    .dataValidIn         (dataValidIn),
    .endTransactionIn    (endTransactionIn),
    .busErrorIn          (busErrorIn)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } ci_exp_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [7:0]  bsz;
    logic        rnw;
  } bus_exp_t;

  ci_exp_t     ci_q[$];
  bus_exp_t    bus_q[$];
  logic [31:0] slave_words[$];
  logic [31:0] ref_mem [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int err_burst   = 0;
  int burst_idx   = 0;
  bit slave_busy  = 0;
  int wr_left     = 0;
  bit end_due     = 0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic take(input int kind, output bus_exp_t e, output bit ok);
    ok = 0;
    if (bus_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL bus_event: got kind %0d expected none (cycle %0d)",
               kind, cyc);
    end else begin
      e  = bus_q.pop_front();
      ok = 1;
      check("bus_event_kind", kind, e.kind);
    end
  endtask

  // Monitor: CI completions and bus activity against the queues
  always @(negedge clock) begin
    ci_exp_t  ce;
    bus_exp_t be;
    bit       ok;
    if (!reset) begin
      if (ci_q.size() != 0 && ci_q[0].cyc <= cyc) begin
        ce = ci_q.pop_front();
        check("ci_done", {31'b0, done}, 32'd1);
        check("ci_result", result, ce.res);
      end else begin
        check("no_spurious_done", {31'b0, done}, 32'd0);
        check("result_zero_idle", result, 32'd0);
      end
      if (wr_left > 0) begin
        check("wr_beat_valid", {31'b0, dataValidOut}, 32'd1);
        take(1, be, ok);
        if (ok) check("wr_beat_data", addressDataOut, be.data);
        wr_left--;
        if (wr_left == 0) end_due = 1;
      end else if (end_due) begin
        check("wr_end_pulse", {31'b0, endTransactionOut}, 32'd1);
        take(2, be, ok);
        end_due = 0;
      end else begin
        check("no_stray_dv", {31'b0, dataValidOut}, 32'd0);
        check("no_stray_end", {31'b0, endTransactionOut}, 32'd0);
        if (beginTransactionOut) begin
          take(0, be, ok);
          if (ok) begin
            check("begin_addr", addressDataOut, be.data);
            check("begin_bsz", {24'b0, burstSizeOut}, {24'b0, be.bsz});
            check("begin_rnw", {31'b0, readNotWriteOut}, {31'b0, be.rnw});
            if (!be.rnw) wr_left = int'(be.bsz) + 1;
          end
        end else begin
          check("bus_idle_zero",
                addressDataOut | {24'b0, burstSizeOut}
                | {31'b0, readNotWriteOut}, 32'd0);
        end
      end
    end
  end

  // Arbiter: grants a pending request after a random delay
  initial begin
    transactionGranted = 1'b0;
    forever begin
      @(negedge clock);
      transactionGranted = requestTransaction && ($urandom_range(0, 2) != 0);
    end
  end

  // Read slave: returns model words with random gaps, or a bus error
  initial begin
    int n, i;
    dataValidIn = 0; endTransactionIn = 0;
    busErrorIn = 0; addressDataIn = '0;
    forever begin
      @(negedge clock);
      if (!reset && beginTransactionOut && readNotWriteOut) begin
        slave_busy = 1;
        burst_idx++;
        n = int'(burstSizeOut) + 1;
        if (burst_idx == err_burst) begin
          @(negedge clock);
          busErrorIn = 1;
        end else begin
          i = 0;
          while (i < n) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
              dataValidIn = 0;
              endTransactionIn = 0;
            end else begin
              dataValidIn = 1;
              addressDataIn = (slave_words.size() != 0)
                            ? slave_words.pop_front() : 32'hBAD0BAD0;
              endTransactionIn = (i == n - 1);
              i++;
            end
          end
        end
        @(negedge clock);
        dataValidIn = 0; endTransactionIn = 0;
        busErrorIn = 0; addressDataIn = '0;
        slave_busy = 0;
      end
    end
  end

  // One CI op; caller sits at a negedge
  task automatic ci(input bit wr, input logic [2:0] sel,
                    input int addr, input logic [31:0] data,
                    input logic [31:0] exp_res);
    ci_exp_t e;
    logic [31:0] a;
    a = '0;
    a[M-1:0]   = addr[M-1:0];
    a[M]       = wr;
    a[M+3:M+1] = sel;
    start  = 1;
    ciN    = 8'h00;
    valueA = a;
    valueB = data;
    e.res  = wr ? 32'd0 : exp_res;
    e.cyc  = cyc + 1;
    ci_q.push_back(e);
    @(negedge clock);
    start = 0; valueA = '0; valueB = '0;
  endtask

  task automatic cfg(input logic [31:0] ba, input int ma,
                     input int blk, input int bst);
    ci(1, S_BUS, 0, ba, 0);
    ci(1, S_MA, 0, ma, 0);
    ci(1, S_BLK, 0, blk, 0);
    ci(1, S_BST, 0, bst, 0);
  endtask

  // Transfer-level model: bursts, addresses, words
  task automatic expect_dma(input bit rd, input logic [31:0] ba,
                            input int ma, input int blk, input int bst,
                            input int errb);
    int rem, p, nb, bt;
    logic [31:0] a, w;
    bus_exp_t e;
    rem = blk; p = ma; a = ba; nb = 0;
    burst_idx = 0;
    err_burst = errb;
    while (rem > 0) begin
      bt = (bst + 1 < rem) ? bst + 1 : rem;
      nb++;
      e.kind = 0; e.data = a; e.bsz = 8'(bt - 1); e.rnw = rd;
      bus_q.push_back(e);
      if (nb == errb) break;
      for (int i = 0; i < bt; i++) begin
        if (rd) begin
          w = $urandom;
          slave_words.push_back(w);
          ref_mem[p] = w;
        end else begin
          e.kind = 1; e.data = ref_mem[p];
          bus_q.push_back(e);
        end
        p = (p + 1) % DEPTH;
      end
      if (!rd) begin
        e.kind = 2; e.data = '0;
        bus_q.push_back(e);
      end
      rem -= bt;
      a += 32'(4 * bt);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clock); #1;
    while ((bus_q.size() != 0 || slave_busy || wr_left != 0 || end_due)
           && t < 3000) begin
      @(negedge clock); #1;
      t++;
    end
    check("dma_done_in_budget", {31'b0, t < 3000}, 32'd1);
    if (t >= 3000) begin
      bus_q.delete(); slave_words.delete();
      wr_left = 0; end_due = 0;
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic dma(input bit rd, input logic [31:0] ba, input int ma,
                     input int blk, input int bst, input int errb,
                     input bit poke);
    logic [31:0] ctl;
    cfg(ba, ma, blk, bst);
    expect_dma(rd, ba, ma, blk, bst, errb);
    ctl = rd ? ($urandom_range(0, 1) ? 32'd3 : 32'd1) : 32'd2;
    ci(1, S_CTL, 0, ctl, 0);
    ci(0, S_CTL, 0, 0, 32'd1);
    if (poke) begin
      ci(1, S_BUS, 0, 32'h9999_0000, 0);
      ci(0, S_BUS, 0, 0, ba);
      ci(1, S_BLK, 0, 7, 0);
      ci(0, S_BLK, 0, 0, blk);
    end
    wait_idle();
    ci(0, S_CTL, 0, 0, (errb > 0) ? 32'd2 : 32'd0);
  endtask

  task automatic check_mem(input int base, input int len);
    for (int i = 0; i < len; i++)
      ci(0, S_MEM, (base + i) % DEPTH, 0, ref_mem[(base + i) % DEPTH]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, reqs;
    logic [31:0] w;
    reset = 1; start = 0; ciN = '0; valueA = '0; valueB = '0;
    repeat (3) @(negedge clock);
    check("reset_ctl_outs",
          {26'b0, done, requestTransaction, beginTransactionOut,
           readNotWriteOut, dataValidOut, endTransactionOut}, 32'd0);
    check("reset_data_outs", addressDataOut | result, 32'd0);
    check("reset_bsz", {24'b0, burstSizeOut}, 32'd0);
    reset = 0;
    @(negedge clock);

    ci(0, S_CTL, 0, 0, 32'd0);
    ci(0, S_BUS, 0, 0, 32'd0);
    ci(0, S_BLK, 0, 0, 32'd0);

    ci(1, S_MEM, 5, 32'hDEADBEEF, 0);
    ci(0, S_MEM, 5, 0, 32'hDEADBEEF);

    start = 1; ciN = 8'h5A; valueA = 32'd5; valueB = '0;
    @(negedge clock);
    start = 0; ciN = '0; valueA = '0;
    @(negedge clock);

    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      ref_mem[i] = w;
      ci(1, S_MEM, i, w, 0);
    end
    check_mem(0, 8);

    dma(1, 32'h0000_1000, 0, 10, 3, 0, 0);
    check_mem(0, 10);

    dma(0, 32'h0000_3000, 510, 4, 7, 0, 0);

    dma(1, 32'h0000_2000, 100, 10, 3, 2, 0);
    check_mem(100, 4);
    ci(1, S_CTL, 0, 0, 0);
    ci(0, S_CTL, 0, 0, 32'd0);

    cfg(32'h0000_6000, 0, 0, 3);
    ci(1, S_CTL, 0, 1, 0);
    ci(0, S_CTL, 0, 0, 32'd0);
    reqs = 0;
    repeat (10) begin
      @(negedge clock);
      if (requestTransaction) reqs++;
    end
    check("block0_no_request", reqs, 0);

    dma(1, 32'h0000_4000, 200, 40, 15, 0, 1);
    check_mem(200, 40);

    dma(1, 32'hFFFF_FFF0, 300, 12, 3, 0, 0);
    check_mem(300, 12);

    for (int k = 0; k < 12; k++) begin
      bit rd;
      int ma, blk, bst;
      logic [31:0] ba;
      rd  = 1'($urandom_range(0, 1));
      ba  = $urandom;
      ma  = $urandom_range(0, DEPTH - 1);
      blk = $urandom_range(1, 24);
      bst = ($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 7);
      dma(rd, ba, ma, blk, bst, 0, 0);
      if (rd) check_mem(ma, blk);
    end

    cfg(32'h0000_5000, 0, 64, 15);
    expect_dma(0, 32'h0000_5000, 0, 64, 15, 0);
    ci(1, S_CTL, 0, 2, 0);
    ci(0, S_CTL, 0, 0, 32'd1);
    t = 0;
    while (!dataValidOut && t < 200) begin
      @(negedge clock);
      t++;
    end
    check("write_beat_seen", {31'b0, dataValidOut}, 32'd1);
    #1;
    reset = 1;
    bus_q.delete(); slave_words.delete();
    wr_left = 0; end_due = 0;
    @(negedge clock);
    check("midreset_ctl_outs",
          {26'b0, done, requestTransaction, beginTransactionOut,
           readNotWriteOut, dataValidOut, endTransactionOut}, 32'd0);
    check("midreset_data_outs", addressDataOut | result, 32'd0);
    check("midreset_bsz", {24'b0, burstSizeOut}, 32'd0);
    reset = 0;
    @(negedge clock);
    ci(0, S_CTL, 0, 0, 32'd0);
    ci(0, S_BUS, 0, 0, 32'd0);
    repeat (3) @(negedge clock);

    check("ci_queue_drained", ci_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
